// File: rtl/pipeline_decode.sv
// RV32I ID stage: decode, 32x32 register file with write-through, immediate generation,
// load-use stall detection and flush, registered into the ID/EX boundary.
module pipeline_decode #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            valid_i,
  input  logic [31:0]     instruction_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush_i,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [XLEN-1:0] imm_o,
  output logic [4:0]      rd_o,
  output logic [2:0]      funct3_o,
  output logic            funct7b5_o,
  output logic            reg_write_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            branch_o,
  output logic            jump_o,
  output logic            jalr_o,
  output logic            alu_src_imm_o,
  output logic            illegal_o
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic [XLEN-1:0] regs [NUM_REGS];

  logic [6:0] opcode;
  logic [4:0] rs1, rs2, rd;
  assign opcode = instruction_i[6:0];
  assign rd     = instruction_i[11:7];
  assign rs1    = instruction_i[19:15];
  assign rs2    = instruction_i[24:20];

  logic            reg_write_d, mem_read_d, mem_write_d, branch_d;
  logic            jump_d, jalr_d, alu_src_d, illegal_d, use_rs1, use_rs2;
  logic [XLEN-1:0] imm_d;

  always_comb begin
    reg_write_d = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    branch_d    = 1'b0;
    jump_d      = 1'b0;
    jalr_d      = 1'b0;
    alu_src_d   = 1'b0;
    illegal_d   = 1'b0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    imm_d       = '0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        imm_d       = XLEN'($signed({instruction_i[31:12], 12'b0}));
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
      end
      OP_JAL: begin
        imm_d       = XLEN'($signed({instruction_i[31], instruction_i[19:12], instruction_i[20],
                                     instruction_i[30:21], 1'b0}));
        reg_write_d = 1'b1;
        jump_d      = 1'b1;
        alu_src_d   = 1'b1;
      end
      OP_JALR: begin
        imm_d       = XLEN'($signed(instruction_i[31:20]));
        reg_write_d = 1'b1;
        jump_d      = 1'b1;
        jalr_d      = 1'b1;
        alu_src_d   = 1'b1;
        use_rs1     = 1'b1;
      end
      OP_BRANCH: begin
        imm_d    = XLEN'($signed({instruction_i[31], instruction_i[7], instruction_i[30:25],
                                  instruction_i[11:8], 1'b0}));
        branch_d = 1'b1;
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
      end
      OP_LOAD: begin
        imm_d       = XLEN'($signed(instruction_i[31:20]));
        reg_write_d = 1'b1;
        mem_read_d  = 1'b1;
        alu_src_d   = 1'b1;
        use_rs1     = 1'b1;
      end
      OP_STORE: begin
        imm_d       = XLEN'($signed({instruction_i[31:25], instruction_i[11:7]}));
        mem_write_d = 1'b1;
        alu_src_d   = 1'b1;
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
      end
      OP_OPIMM: begin
        imm_d       = XLEN'($signed(instruction_i[31:20]));
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        use_rs1     = 1'b1;
      end
      OP_OP: begin
        reg_write_d = 1'b1;
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
      end
      default: illegal_d = 1'b1;
    endcase
    if (rd == 5'd0) reg_write_d = 1'b0;
  end

  // Write-through: a writeback to the register being read this cycle is seen immediately.
  logic [XLEN-1:0] rs1_val, rs2_val;
  assign rs1_val = (rs1 == 5'd0) ? '0 :
                   (wb_we_i && wb_rd_i == rs1) ? wb_data_i : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 :
                   (wb_we_i && wb_rd_i == rs2) ? wb_data_i : regs[rs2];

  logic hazard, kill;
  assign hazard  = valid_o && mem_read_o && (rd_o != 5'd0) &&
                   ((use_rs1 && rs1 == rd_o) || (use_rs2 && rs2 == rd_o));
  assign stall_o = valid_i && hazard;
  assign kill    = flush_i || stall_o || !valid_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      valid_o       <= 1'b0;
      pc_o          <= '0;
      rs1_data_o    <= '0;
      rs2_data_o    <= '0;
      imm_o         <= '0;
      rd_o          <= '0;
      funct3_o      <= '0;
      funct7b5_o    <= 1'b0;
      reg_write_o   <= 1'b0;
      mem_read_o    <= 1'b0;
      mem_write_o   <= 1'b0;
      branch_o      <= 1'b0;
      jump_o        <= 1'b0;
      jalr_o        <= 1'b0;
      alu_src_imm_o <= 1'b0;
      illegal_o     <= 1'b0;
    end else begin
      if (wb_we_i && wb_rd_i != 5'd0) regs[wb_rd_i] <= wb_data_i;
      // Datapath fields latch every cycle; they are don't-care whenever valid_o is low.
      pc_o          <= pc_i;
      rs1_data_o    <= rs1_val;
      rs2_data_o    <= rs2_val;
      imm_o         <= imm_d;
      rd_o          <= rd;
      funct3_o      <= instruction_i[14:12];
      funct7b5_o    <= instruction_i[30];
      valid_o       <= !kill;
      reg_write_o   <= reg_write_d && !kill;
      mem_read_o    <= mem_read_d  && !kill;
      mem_write_o   <= mem_write_d && !kill;
      branch_o      <= branch_d    && !kill;
      jump_o        <= jump_d      && !kill;
      jalr_o        <= jalr_d      && !kill;
      alu_src_imm_o <= alu_src_d   && !kill;
      illegal_o     <= illegal_d   && !kill;
    end
  end

endmodule

// File: tb/tb_pipeline_decode.sv
// Bench for pipeline_decode: directed scenarios plus randomized traffic checked against
// an instruction-level reference model of the ID stage and register file.
module tb_pipeline_decode;

  logic        clk_i = 1'b0;
  logic        reset_i, valid_i, flush_i, wb_we_i;
  logic [31:0] instruction_i, pc_i, wb_data_i;
  logic [4:0]  wb_rd_i;
  logic        stall_o, valid_o, funct7b5_o, reg_write_o, mem_read_o, mem_write_o;
  logic        branch_o, jump_o, jalr_o, alu_src_imm_o, illegal_o;
  logic [31:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
  logic [4:0]  rd_o;
  logic [2:0]  funct3_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] pc_cnt = 32'h1000;

  always #5 clk_i = ~clk_i;

  pipeline_decode dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .instruction_i(instruction_i),
    .pc_i(pc_i), .flush_i(flush_i), .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .stall_o(stall_o), .valid_o(valid_o), .pc_o(pc_o), .rs1_data_o(rs1_data_o),
    .rs2_data_o(rs2_data_o), .imm_o(imm_o), .rd_o(rd_o), .funct3_o(funct3_o),
    .funct7b5_o(funct7b5_o), .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .branch_o(branch_o), .jump_o(jump_o), .jalr_o(jalr_o),
    .alu_src_imm_o(alu_src_imm_o), .illegal_o(illegal_o)
  );

  logic [7:0] dut_ctl;
  assign dut_ctl = {reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o, jalr_o,
                    alu_src_imm_o, illegal_o};

  // ---------------- reference model ----------------
  logic [31:0] rf [32];
  logic        m_valid;
  logic [7:0]  m_ctl;
  logic [31:0] m_pc, m_rs1, m_rs2, m_imm;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic        m_f7;

  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    int v;
    v = 0;
    case (ins[6:0])
      7'b0110111, 7'b0010111: return {ins[31:12], 12'h000};
      7'b1100111, 7'b0000011, 7'b0010011: v = int'(ins[30:20]) - (ins[31] ? 2048 : 0);
      7'b0100011: v = int'(ins[30:25]) * 32 + int'(ins[11:7]) - (ins[31] ? 2048 : 0);
      7'b1100011: v = int'(ins[11:8]) * 2 + int'(ins[30:25]) * 32 + int'(ins[7]) * 2048
                      - (ins[31] ? 4096 : 0);
      7'b1101111: v = int'(ins[30:21]) * 2 + int'(ins[20]) * 2048 + int'(ins[19:12]) * 4096
                      - (ins[31] ? (1 << 20) : 0);
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  // {reg_write, mem_read, mem_write, branch, jump, jalr, alu_src_imm, illegal}
  function automatic logic [7:0] ref_ctl(input logic [31:0] ins);
    logic rw = 0, mr = 0, mw = 0, br = 0, j = 0, jr = 0, as = 0, il = 0;
    case (ins[6:0])
      7'b0110111, 7'b0010111: begin rw = 1; as = 1; end
      7'b1101111: begin rw = 1; j = 1; as = 1; end
      7'b1100111: begin rw = 1; j = 1; jr = 1; as = 1; end
      7'b1100011: br = 1;
      7'b0000011: begin rw = 1; mr = 1; as = 1; end
      7'b0100011: begin mw = 1; as = 1; end
      7'b0010011: begin rw = 1; as = 1; end
      7'b0110011: rw = 1;
      default: il = 1;
    endcase
    return {rw && (ins[11:7] != 5'd0), mr, mw, br, j, jr, as, il};
  endfunction

  function automatic logic reads_reg(input logic [31:0] ins, input logic [4:0] r);
    logic u1, u2;
    u1 = ins[6:0] inside {7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    u2 = ins[6:0] inside {7'b1100011, 7'b0100011, 7'b0110011};
    return (u1 && ins[19:15] == r) || (u2 && ins[24:20] == r);
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (wb_we_i && wb_rd_i == r) return wb_data_i;
    return rf[r];
  endfunction

  function automatic logic exp_stall();
    return valid_i && m_valid && m_ctl[6] && (m_rd != 5'd0) && reads_reg(instruction_i, m_rd);
  endfunction

  always @(posedge clk_i) begin : model
    logic st;
    st = exp_stall();
    if (reset_i) begin
      m_valid = 1'b0;
      m_ctl   = 8'h00;
      for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    end else begin
      if (valid_i && !flush_i && !st) begin
        m_valid = 1'b1;
        m_ctl   = ref_ctl(instruction_i);
        m_pc    = pc_i;
        m_rs1   = ref_read(instruction_i[19:15]);
        m_rs2   = ref_read(instruction_i[24:20]);
        m_imm   = ref_imm(instruction_i);
        m_rd    = instruction_i[11:7];
        m_f3    = instruction_i[14:12];
        m_f7    = instruction_i[30];
      end else begin
        m_valid = 1'b0;
        m_ctl   = 8'h00;
      end
      if (wb_we_i && wb_rd_i != 5'd0) rf[wb_rd_i] = wb_data_i;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input logic v, input logic [31:0] ins, input logic fl,
                        input logic we, input logic [4:0] wr, input logic [31:0] wd);
    valid_i       = v;
    instruction_i = ins;
    flush_i       = fl;
    wb_we_i       = we;
    wb_rd_i       = wr;
    wb_data_i     = wd;
    pc_i          = pc_cnt;
    pc_cnt        = pc_cnt + 4;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, op};
  endfunction

  localparam logic [6:0] LOAD = 7'b0000011, OP = 7'b0110011, OPIMM = 7'b0010011;

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] ins;
    reset_i = 1'b1;
    set_in(1'b1, 32'h00500313, 1'b1, 1'b1, 5'd5, 32'hFFFF_0000);
    tick();
    tick();
    checks++;
    if ({valid_o, dut_ctl, pc_o, rs1_data_o, rs2_data_o, imm_o, rd_o, funct3_o, funct7b5_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b ctl=%b pc=%h rs1=%h rs2=%h imm=%h rd=%0d, required all zero",
               valid_o, dut_ctl, pc_o, rs1_data_o, rs2_data_o, imm_o, rd_o);
    end
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: got %b required 0", stall_o);
    end
    reset_i = 1'b0;
    for (int n = 1; n < 32; n++) begin
      ins = {12'd0, 5'(n), 3'b000, 5'd0, OPIMM};
      set_in(1'b1, ins, 1'b0, 1'b0, 5'd0, 32'h0);
      tick();
      checks++;
      if (rs1_data_o !== 32'h0 || valid_o !== 1'b1) begin
        errors++;
        $display("FAIL reset_regfile x%0d: rs1_data=%h valid=%b required 0 / 1", n, rs1_data_o, valid_o);
      end
    end
  endtask

  task automatic test_bypass();
    set_in(1'b1, enc_r(OP, 5'd6, 5'd5, 5'd0), 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    checks++;
    if (rs1_data_o !== 32'hDEADBEEF || rs2_data_o !== 32'h0 || reg_write_o !== 1'b1) begin
      errors++;
      $display("FAIL bypass: rs1=%h rs2=%h rw=%b required deadbeef 0 1", rs1_data_o, rs2_data_o, reg_write_o);
    end
  endtask

  task automatic test_load_use();
    logic [31:0] lw7, add8, lw0, add_x0;
    lw7    = {12'd0, 5'd1, 3'b010, 5'd7, LOAD};
    add8   = enc_r(OP, 5'd8, 5'd7, 5'd2);
    lw0    = {12'd0, 5'd1, 3'b010, 5'd0, LOAD};
    add_x0 = enc_r(OP, 5'd8, 5'd0, 5'd2);
    set_in(1'b0, 32'h0, 1'b0, 1'b1, 5'd2, 32'h0000_0022); tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b1, 5'd7, 32'h0000_0077); tick();
    set_in(1'b1, lw7, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    checks++;
    if (valid_o !== 1'b1 || mem_read_o !== 1'b1 || rd_o !== 5'd7) begin
      errors++;
      $display("FAIL load_issue: valid=%b mem_read=%b rd=%0d required 1 1 7", valid_o, mem_read_o, rd_o);
    end
    set_in(1'b1, add8, 1'b0, 1'b0, 5'd0, 32'h0);
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL load_use_stall: got %b required 1", stall_o);
    end
    tick();
    checks++;
    if (valid_o !== 1'b0 || dut_ctl !== 8'h00) begin
      errors++;
      $display("FAIL load_use_bubble: valid=%b ctl=%b required 0 00000000", valid_o, dut_ctl);
    end
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL load_use_single_stall: got %b required 0", stall_o);
    end
    tick();
    checks++;
    if (valid_o !== 1'b1 || rs1_data_o !== 32'h77 || rs2_data_o !== 32'h22 || rd_o !== 5'd8) begin
      errors++;
      $display("FAIL load_use_resume: valid=%b rs1=%h rs2=%h rd=%0d required 1 77 22 8",
               valid_o, rs1_data_o, rs2_data_o, rd_o);
    end
    set_in(1'b1, lw0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    checks++;
    if (mem_read_o !== 1'b1 || reg_write_o !== 1'b0) begin
      errors++;
      $display("FAIL load_x0: mem_read=%b reg_write=%b required 1 0", mem_read_o, reg_write_o);
    end
    set_in(1'b1, add_x0, 1'b0, 1'b0, 5'd0, 32'h0);
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL load_x0_nostall: got %b required 0", stall_o);
    end
    tick();
  endtask

  task automatic test_imm();
    logic [31:0] ins_t [4];
    logic [31:0] imm_t [4];
    ins_t = '{32'hFFF00093, 32'hFE000EE3, 32'h123450B7, 32'h801FF0EF};
    imm_t = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'hFFFFF800};
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, ins_t[k], 1'b0, 1'b0, 5'd0, 32'h0);
      tick();
      checks++;
      if (imm_o !== imm_t[k]) begin
        errors++;
        $display("FAIL imm_%0d: got %h required %h", k, imm_o, imm_t[k]);
      end
    end
    checks++;
    if (jump_o !== 1'b1 || jalr_o !== 1'b0 || reg_write_o !== 1'b1) begin
      errors++;
      $display("FAIL jal_ctl: jump=%b jalr=%b rw=%b required 1 0 1", jump_o, jalr_o, reg_write_o);
    end
  endtask

  task automatic test_flush();
    set_in(1'b1, {12'd0, 5'd1, 3'b010, 5'd7, LOAD}, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    set_in(1'b1, enc_r(OP, 5'd8, 5'd7, 5'd2), 1'b1, 1'b0, 5'd0, 32'h0);
    tick();
    checks++;
    if (valid_o !== 1'b0 || dut_ctl !== 8'h00) begin
      errors++;
      $display("FAIL flush_bubble: valid=%b ctl=%b required 0 00000000", valid_o, dut_ctl);
    end
    set_in(1'b1, enc_r(OP, 5'd8, 5'd7, 5'd2), 1'b0, 1'b0, 5'd0, 32'h0);
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_after_stall: got %b required 0", stall_o);
    end
    tick();
    checks++;
    if (valid_o !== 1'b1 || reg_write_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_resume: valid=%b rw=%b required 1 1", valid_o, reg_write_o);
    end
  endtask

  task automatic test_illegal();
    set_in(1'b1, 32'h000002FF, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    checks++;
    if (valid_o !== 1'b1 || dut_ctl !== 8'h01) begin
      errors++;
      $display("FAIL illegal_valid: valid=%b ctl=%b required 1 00000001", valid_o, dut_ctl);
    end
    set_in(1'b0, 32'h000002FF, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    checks++;
    if (valid_o !== 1'b0 || illegal_o !== 1'b0) begin
      errors++;
      $display("FAIL illegal_invalid: valid=%b illegal=%b required 0 0", valid_o, illegal_o);
    end
    set_in(1'b1, enc_r(OP, 5'd1, 5'd0, 5'd0), 1'b0, 1'b1, 5'd0, 32'h1234);
    tick();
    checks++;
    if (rs1_data_o !== 32'h0) begin
      errors++;
      $display("FAIL x0_write_bypass: got %h required 0", rs1_data_o);
    end
    set_in(1'b1, enc_r(OP, 5'd1, 5'd0, 5'd0), 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    checks++;
    if (rs1_data_o !== 32'h0 || rs2_data_o !== 32'h0) begin
      errors++;
      $display("FAIL x0_stays_zero: rs1=%h rs2=%h required 0 0", rs1_data_o, rs2_data_o);
    end
  endtask

  task automatic test_random();
    logic [6:0]  op_tbl [10];
    logic [31:0] ins;
    logic        v, hold, st;
    op_tbl = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
               7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'h7F};
    ins  = 32'h0;
    v    = 1'b0;
    hold = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!hold) begin
        ins        = $urandom;
        ins[6:0]   = ($urandom_range(0, 2) == 0) ? op_tbl[5] : op_tbl[$urandom_range(0, 9)];
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        v          = ($urandom_range(0, 9) != 0);
      end
      set_in(v, ins, ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1),
             5'($urandom_range(0, 7)), $urandom);
      st = exp_stall();
      checks++;
      if (stall_o !== st) begin
        errors++;
        $display("FAIL rand_stall c=%0d: got %b required %b", c, stall_o, st);
      end
      hold = st && !flush_i;
      tick();
      checks++;
      if (valid_o !== m_valid || dut_ctl !== m_ctl) begin
        errors++;
        $display("FAIL rand_ctl c=%0d: valid=%b ctl=%b required %b %b", c, valid_o, dut_ctl, m_valid, m_ctl);
      end
      if (m_valid) begin
        checks++;
        if ({pc_o, rs1_data_o, rs2_data_o, imm_o, rd_o, funct3_o, funct7b5_o} !==
            {m_pc, m_rs1, m_rs2, m_imm, m_rd, m_f3, m_f7}) begin
          errors++;
          $display("FAIL rand_data c=%0d: pc=%h rs1=%h rs2=%h imm=%h rd=%0d f3=%0d f7=%b required %h %h %h %h %0d %0d %b",
                   c, pc_o, rs1_data_o, rs2_data_o, imm_o, rd_o, funct3_o, funct7b5_o,
                   m_pc, m_rs1, m_rs2, m_imm, m_rd, m_f3, m_f7);
        end
      end
    end
  endtask

  initial begin
    reset_i = 1'b1;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    test_reset();
    test_bypass();
    test_load_use();
    test_imm();
    test_flush();
    test_illegal();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
